// File: rtl/m_pool_1.sv
// m_pool_1: ReLU followed by 2x2 stride-2 max pooling over a strobed raster stream.
// Columns pair up through hold_q and rows pair up through a half-row line buffer.
module m_pool_1 #(
    parameter int map_w   = 88,
    parameter int map_h   = 88,
    parameter int num_out = 1936
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] map_in,
    input  logic        save_in,
    output logic [15:0] map_out,
    output logic        save,
    output logic        ready
);
    localparam int COL_W = $clog2(map_w);
    localparam int ROW_W = $clog2(map_h);
    localparam int CNT_W = $clog2(num_out + 1);
    localparam int IDX_W = COL_W - 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [15:0]      hold_q, hold_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             done_q, done_d;
    logic [15:0]      map_out_q, map_out_d;
    logic             save_q, save_d;
    logic             ready_q, ready_d;

    logic [15:0]      lbuf_q [map_w/2];
    logic             lbuf_we;
    logic [IDX_W-1:0] lbuf_idx;
    logic [15:0]      lbuf_rd;
    logic [15:0]      relu;
    logic [15:0]      h_max;
    logic [15:0]      v_max;
    logic             accept;

    always_comb begin
        relu     = map_in[15] ? 16'd0 : map_in;
        h_max    = ($signed(hold_q) > $signed(relu)) ? hold_q : relu;
        lbuf_idx = col_q[COL_W-1:1];
        lbuf_rd  = lbuf_q[lbuf_idx];
        v_max    = ($signed(lbuf_rd) > $signed(h_max)) ? lbuf_rd : h_max;
        accept   = start && save_in && !done_q;

        col_d     = col_q;
        row_d     = row_q;
        hold_d    = hold_q;
        out_cnt_d = out_cnt_q;
        done_d    = done_q;
        map_out_d = map_out_q;
        save_d    = 1'b0;
        ready_d   = !done_q;
        lbuf_we   = 1'b0;

        if (!start) begin
            // Dropping start abandons any partially collected window.
            col_d  = '0;
            row_d  = '0;
            hold_d = '0;
        end else if (accept) begin
            if (!col_q[0]) begin
                hold_d = relu;
            end else if (!row_q[0]) begin
                lbuf_we = 1'b1;
            end else begin
                map_out_d = v_max;
                save_d    = 1'b1;
                out_cnt_d = out_cnt_q + 1'b1;
                if (out_cnt_q == CNT_W'(num_out - 1)) begin
                    done_d = 1'b1;
                end
            end

            if (col_q == COL_W'(map_w - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(map_h - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
            map_out_q <= '0;
            save_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            hold_q    <= hold_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
            map_out_q <= map_out_d;
            save_q    <= save_d;
            ready_q   <= ready_d;
        end
    end

    // Line buffer holds the even-row horizontal maxima; every entry is rewritten before it is read.
    always_ff @(posedge clk_in) begin
        if (lbuf_we) begin
            lbuf_q[lbuf_idx] <= h_max;
        end
    end

    assign map_out = map_out_q;
    assign save    = save_q;
    assign ready   = ready_q;
endmodule

// File: tb/tb_m_pool_1.sv
// Bench for m_pool_1: frames are built as pixel arrays and the expected pooled stream
// is taken as max(0, four window pixels) per 2x2 block in raster order.
module tb_m_pool_1;
    localparam int W = 88;
    localparam int H = 88;
    localparam int N = (W / 2) * (H / 2);

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] map_in;
    logic        save_in;
    logic [15:0] map_out;
    logic        save;
    logic        ready;

    int pass_cnt = 0;
    int total_cnt = 0;
    int px [W*H];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    m_pool_1 #(.map_w(W), .map_h(H), .num_out(N)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .start  (start),
        .map_in (map_in),
        .save_in(save_in),
        .map_out(map_out),
        .save   (save),
        .ready  (ready)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (save === 1'b1) got_q.push_back(map_out);
    end

    function automatic void build_exp();
        int m;
        int v;
        exp_q.delete();
        for (int i = 0; i < H / 2; i++) begin
            for (int j = 0; j < W / 2; j++) begin
                m = 0;
                for (int di = 0; di < 2; di++)
                    for (int dj = 0; dj < 2; dj++) begin
                        v = px[(2 * i + di) * W + 2 * j + dj];
                        if (v > m) m = v;
                    end
                exp_q.push_back(16'(m));
            end
        end
    endfunction

    function automatic void fill_ramp();
        for (int k = 0; k < W * H; k++) px[k] = k;
    endfunction

    function automatic void fill_random();
        logic signed [15:0] t;
        for (int k = 0; k < W * H; k++) begin
            t = 16'($urandom_range(0, 65535));
            px[k] = int'(t);
        end
    endfunction

    task automatic drive_val(input logic [15:0] v, input int gap);
        @(negedge clk_in);
        map_in  = v;
        save_in = 1'b1;
        repeat (gap) begin
            @(negedge clk_in);
            save_in = 1'b0;
            map_in  = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic drive_range(input int first, input int last, input int gap_max);
        for (int k = first; k <= last; k++)
            drive_val(16'(px[k]), (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            save_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n   = 1'b1;
        start   = 1'b0;
        save_in = 1'b0;
        map_in  = 16'd0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b0;
        start = 1'b1;
        got_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; save_in = 1'b0; map_in = 16'd0;
        #2 rst_n = 1'b1;
        #1;
        total_cnt++; if (map_out !== 16'd0) $display("FAIL reset_map_out got %0d exp 0", map_out); else pass_cnt++;
        total_cnt++; if (save !== 1'b0) $display("FAIL reset_save got %b exp 0", save); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < W * H; k++) px[k] = 0;
        px[0] = 5; px[1] = -3; px[W] = 7; px[W + 1] = 2;
        build_exp();
        drive_range(0, W + 1, 0);
        @(negedge clk_in);
        save_in = 1'b0;
        total_cnt++; if (save !== 1'b1) $display("FAIL single_latency save got %b exp 1", save); else pass_cnt++;
        total_cnt++; if (map_out !== 16'd7) $display("FAIL single_first got %0d exp 7", map_out); else pass_cnt++;
        drive_range(W + 2, W * H - 1, 0);
        idle(3);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL single_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
        total_cnt++; if (ready !== 1'b0) $display("FAIL single_ready got %b exp 0", ready); else pass_cnt++;
    endtask

    task automatic test_relu();
        do_reset();
        for (int k = 0; k < W * H; k++) px[k] = -100;
        build_exp();
        drive_range(0, W * H - 1, 0);
        idle(3);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL relu_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL relu_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_ramp();
        do_reset();
        fill_ramp();
        build_exp();
        drive_range(0, W * H - 1, 0);
        @(negedge clk_in);
        save_in = 1'b0;
        total_cnt++; if (save !== 1'b1) $display("FAIL ramp_last_save got %b exp 1", save); else pass_cnt++;
        total_cnt++; if (map_out !== 16'(W * H - 1)) $display("FAIL ramp_last_val got %0d exp %0d", map_out, W * H - 1); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL ramp_ready_early got %b exp 1", ready); else pass_cnt++;
        @(negedge clk_in);
        total_cnt++; if (save !== 1'b0) $display("FAIL ramp_save_drop got %b exp 0", save); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL ramp_ready_fall got %b exp 0", ready); else pass_cnt++;
        idle(2);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL ramp_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL ramp_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_completion();
        got_q.delete();
        for (int k = 0; k < 2 * W; k++) drive_val(16'($urandom_range(1, 30000)), 0);
        idle(3);
        total_cnt++; if (got_q.size() !== 0) $display("FAIL done_extra got %0d outputs exp 0", got_q.size()); else pass_cnt++;
        total_cnt++; if (ready !== 1'b0) $display("FAIL done_ready got %b exp 0", ready); else pass_cnt++;
        total_cnt++; if (map_out !== 16'(W * H - 1)) $display("FAIL done_hold got %0d exp %0d", map_out, W * H - 1); else pass_cnt++;
        @(posedge clk_in);
        #2 rst_n = 1'b1;
        #1;
        total_cnt++; if (ready !== 1'b1) $display("FAIL async_ready got %b exp 1", ready); else pass_cnt++;
        total_cnt++; if (map_out !== 16'd0) $display("FAIL async_map_out got %0d exp 0", map_out); else pass_cnt++;
        @(negedge clk_in);
        rst_n = 1'b0;
    endtask

    task automatic test_gapped();
        do_reset();
        fill_ramp();
        build_exp();
        drive_range(0, W * H - 1, 5);
        idle(3);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL gap_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL gap_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        do_reset();
        fill_random();
        build_exp();
        drive_range(0, W * H - 1, 1);
        idle(3);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL rand_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
        total_cnt++; if (ready !== 1'b0) $display("FAIL rand_ready got %b exp 0", ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_ramp();
        drive_range(0, W + 5, 0);
        @(posedge clk_in);
        #1;
        total_cnt++; if (save !== 1'b1) $display("FAIL mid_pre_save got %b exp 1", save); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (save !== 1'b0) $display("FAIL mid_save got %b exp 0", save); else pass_cnt++;
        total_cnt++; if (map_out !== 16'd0) $display("FAIL mid_map_out got %0d exp 0", map_out); else pass_cnt++;
        save_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b0;
        got_q.delete();
        fill_random();
        build_exp();
        drive_range(0, W * H - 1, 0);
        idle(3);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL mid_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL mid_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
    endtask

    task automatic test_start_abort();
        do_reset();
        for (int k = 0; k <= W; k++) drive_val(16'(30000 - k), 0);
        idle(1);
        start = 1'b0;
        idle(3);
        total_cnt++; if (got_q.size() !== 0) $display("FAIL abort_partial got %0d outputs exp 0", got_q.size()); else pass_cnt++;
        start = 1'b1;
        fill_ramp();
        build_exp();
        drive_range(0, W * H - 1, 0);
        idle(3);
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL abort_count got %0d exp %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total_cnt++;
            if (got_q[k] !== exp_q[k]) $display("FAIL abort_out[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]); else pass_cnt++;
        end
        total_cnt++; if (ready !== 1'b0) $display("FAIL abort_ready got %b exp 0", ready); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_relu();
        test_ramp();
        test_completion();
        test_gapped();
        test_random();
        test_reset_mid();
        test_start_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
